// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (IF) and load/store (D); one access in flight.
// Grant-to-rvalid is MEM_LATENCY+2 cycles; requesters hold req until gnt, D has priority with a bounded streak.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    arb_busy
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic            owner_d;
  logic            drop;
  logic [SW-1:0]   streak;
  logic [CW-1:0]   cnt;
  logic            if_elig;
  logic            pick_if;
  logic            pick_d;

  // Grants are combinational so a requester can be accepted in the rvalid cycle.
  always_comb begin
    if_elig = if_req & ~if_flush;
    pick_if = 1'b0;
    pick_d  = 1'b0;
    if (reset_n && state == IDLE) begin
      if (if_elig && (!d_req || streak == SW'(MAX_DATA_STREAK)))
        pick_if = 1'b1;
      else if (d_req)
        pick_d = 1'b1;
    end
  end

  assign if_gnt   = pick_if;
  assign d_gnt    = pick_d;
  assign arb_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      drop      <= 1'b0;
      streak    <= '0;
      cnt       <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      // Streak only measures D wins while IF is actually waiting.
      if (!if_elig || pick_if)
        streak <= '0;
      else if (pick_d)
        streak <= streak + SW'(1);

      case (state)
        IDLE: begin
          if (pick_if || pick_d) begin
            state     <= ISSUE;
            owner_d   <= pick_d;
            mem_req   <= 1'b1;
            mem_we    <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            mem_be    <= (pick_d && d_we) ? d_be : '1;
          end
        end
        ISSUE: begin
          mem_req <= 1'b0;
          cnt     <= CW'(MEM_LATENCY - 1);
          state   <= WAIT;
          if (!owner_d && if_flush)
            drop <= 1'b1;
        end
        WAIT: begin
          if (!owner_d && if_flush)
            drop <= 1'b1;
          if (cnt == '0) begin
            state <= IDLE;
            drop  <= 1'b0;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              if (!mem_we)
                d_rdata <= mem_rdata;
            end else if (!drop && !if_flush) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
